// File: rtl/word_change_fifo.sv
// ---------------------------------------------------------------------------
// word_change_fifo
//
// Watches the registered output word of the upstream XOR-accumulator stage,
// detects when it changes and queues each change as a {word, timestamp} event
// in a small first-word-fall-through FIFO. The readout side drains events over
// a valid/ready handshake. Events that arrive while the FIFO is full are
// dropped and accounted for with a sticky overflow flag and a saturating
// drop counter.
//
// Ports
//   clk       : single clock, rising edge
//   rst       : asynchronous reset, active-low
//   din       : monitored word
//   en        : sample enable, din ignored when low
//   clr       : synchronous clear of overflow and drop_cnt
//   ev_valid  : FIFO head holds an event
//   ev_ready  : consumer accepts the head when ev_valid is high
//   ev_word   : head event word (0 when ev_valid is low)
//   ev_ts     : head event timestamp (0 when ev_valid is low)
//   overflow  : sticky, at least one event dropped since reset/clr
//   drop_cnt  : number of dropped events, saturates at 255
// ---------------------------------------------------------------------------
module word_change_fifo #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 4,
    parameter int TS_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WIDTH-1:0]    din,
    input  logic                en,
    input  logic                clr,
    output logic                ev_valid,
    input  logic                ev_ready,
    output logic [WIDTH-1:0]    ev_word,
    output logic [TS_WIDTH-1:0] ev_ts,
    output logic                overflow,
    output logic [7:0]          drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FullCount = DEPTH[AW:0];

    logic [TS_WIDTH-1:0] ts_q,       ts_d;
    logic [WIDTH-1:0]    prevWord_q, prevWord_d;
    logic                primed_q,   primed_d;
    logic [AW-1:0]       rdPtr_q,    rdPtr_d;
    logic [AW-1:0]       wrPtr_q,    wrPtr_d;
    logic [AW:0]         count_q,    count_d;
    logic                overflow_q, overflow_d;
    logic [7:0]          dropCnt_q,  dropCnt_d;

    logic [WIDTH-1:0]    wordMem_q [DEPTH];
    logic [TS_WIDTH-1:0] tsMem_q   [DEPTH];

    logic change;
    logic isEmpty;
    logic isFull;
    logic pop;
    logic push;
    logic drop;

    // A simultaneous pop frees the head slot at the same edge, so a change
    // arriving at a full FIFO is still accepted when the consumer is ready.
    always_comb begin
        change  = en && primed_q && (din != prevWord_q);
        isEmpty = (count_q == '0);
        isFull  = (count_q == FullCount);
        pop     = !isEmpty && ev_ready;
        push    = change && (!isFull || pop);
        drop    = change && isFull && !pop;
    end

    // Next-state for timestamp, sampling history, pointers and occupancy.
    always_comb begin
        ts_d       = ts_q + TS_WIDTH'(1);
        prevWord_d = prevWord_q;
        primed_d   = primed_q;
        if (en) begin
            prevWord_d = din;
            primed_d   = 1'b1;
        end

        rdPtr_d = pop  ? rdPtr_q + AW'(1) : rdPtr_q;
        wrPtr_d = push ? wrPtr_q + AW'(1) : wrPtr_q;

        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Loss accounting. A drop in the same cycle as clr survives the clear as
    // a single fresh drop.
    always_comb begin
        overflow_d = overflow_q;
        dropCnt_d  = dropCnt_q;
        if (clr) begin
            overflow_d = drop;
            dropCnt_d  = drop ? 8'd1 : 8'd0;
        end else if (drop) begin
            overflow_d = 1'b1;
            dropCnt_d  = (dropCnt_q == 8'hFF) ? 8'hFF : dropCnt_q + 8'd1;
        end
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ts_q       <= '0;
            prevWord_q <= '0;
            primed_q   <= 1'b0;
            rdPtr_q    <= '0;
            wrPtr_q    <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            dropCnt_q  <= '0;
        end else begin
            ts_q       <= ts_d;
            prevWord_q <= prevWord_d;
            primed_q   <= primed_d;
            rdPtr_q    <= rdPtr_d;
            wrPtr_q    <= wrPtr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            dropCnt_q  <= dropCnt_d;
        end
    end

    // Event storage needs no reset: outputs are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            wordMem_q[wrPtr_q] <= din;
            tsMem_q[wrPtr_q]   <= ts_q;
        end
    end

    always_comb begin
        ev_valid = !isEmpty;
        ev_word  = isEmpty ? '0 : wordMem_q[rdPtr_q];
        ev_ts    = isEmpty ? '0 : tsMem_q[rdPtr_q];
        overflow = overflow_q;
        drop_cnt = dropCnt_q;
    end

endmodule

// File: tb/tb_word_change_fifo.sv
// ---------------------------------------------------------------------------
// tb_word_change_fifo
//
// Directed bench for word_change_fifo (WIDTH=8, DEPTH=4, TS_WIDTH=8).
// Inputs change 1 time unit after each rising edge; outputs are checked at
// the same point, well away from the next active edge.
// ---------------------------------------------------------------------------
module tb_word_change_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic       en;
    logic       clr;
    logic       ev_valid;
    logic       ev_ready;
    logic [7:0] ev_word;
    logic [7:0] ev_ts;
    logic       overflow;
    logic [7:0] drop_cnt;

    int checks = 0;
    int errors = 0;

    // Number of rising edges seen since reset release, i.e. the DUT timestamp.
    logic [7:0] tsModel;
    logic [7:0] tsSeen [6];

    always #5 clk = ~clk;

    word_change_fifo #(.WIDTH(8), .DEPTH(4), .TS_WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .en       (en),
        .clr      (clr),
        .ev_valid (ev_valid),
        .ev_ready (ev_ready),
        .ev_word  (ev_word),
        .ev_ts    (ev_ts),
        .overflow (overflow),
        .drop_cnt (drop_cnt)
    );

    task automatic applyStimulus(input logic enV, input logic [7:0] dinV,
                                 input logic readyV, input logic clrV);
        en       = enV;
        din      = dinV;
        ev_ready = readyV;
        clr      = clrV;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rst) tsModel = tsModel + 8'd1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkHead(input string tag, input logic [7:0] w, input logic [7:0] t);
        checkOutput({tag, "_valid"}, 32'(ev_valid), 32'd1);
        checkOutput({tag, "_word"},  32'(ev_word),  32'(w));
        checkOutput({tag, "_ts"},    32'(ev_ts),    32'(t));
    endtask

    task automatic checkEmpty(input string tag);
        checkOutput({tag, "_valid"}, 32'(ev_valid), 32'd0);
        checkOutput({tag, "_word"},  32'(ev_word),  32'd0);
        checkOutput({tag, "_ts"},    32'(ev_ts),    32'd0);
    endtask

    initial begin
        rst     = 1'b0;
        tsModel = 8'd0;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        #12;
        checkEmpty("reset");
        checkOutput("reset_overflow", 32'(overflow), 32'd0);
        checkOutput("reset_dropcnt",  32'(drop_cnt), 32'd0);

        // Baseline, repeated value, two changes, hand-computed timestamps 2 and 4.
        rst     = 1'b1;
        tsModel = 8'd0;
        applyStimulus(1'b1, 8'h00, 1'b0, 1'b0); tick();
        checkEmpty("t1_baseline");
        applyStimulus(1'b1, 8'h00, 1'b0, 1'b0); tick();
        checkEmpty("t1_same");
        applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0); tick();
        checkHead("t1_ev0", 8'h5A, 8'd2);
        applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0); tick();
        applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0); tick();
        checkHead("t1_hold", 8'h5A, 8'd2);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0); tick();
        checkHead("t1_ev1", 8'hA5, 8'd4);
        tick();
        checkEmpty("t1_drained");
        tick();
        checkEmpty("t1_ready_on_empty");

        // Six consecutive changes into a 4-deep FIFO: two dropped.
        for (int k = 0; k < 6; k++) begin
            tsSeen[k] = tsModel;
            applyStimulus(1'b1, 8'(k + 1), 1'b0, 1'b0);
            tick();
        end
        checkOutput("t2_overflow", 32'(overflow), 32'd1);
        checkOutput("t2_dropcnt",  32'(drop_cnt), 32'd2);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            checkHead($sformatf("t2_drain%0d", k), 8'(k + 1), tsSeen[k]);
            tick();
        end
        checkEmpty("t2_empty");

        // Fill, then push and pop together while full.
        for (int k = 0; k < 4; k++) begin
            tsSeen[k] = tsModel;
            applyStimulus(1'b1, 8'h11 + 8'(k), 1'b0, 1'b0);
            tick();
        end
        checkHead("t3_full_head", 8'h11, tsSeen[0]);
        tsSeen[4] = tsModel;
        applyStimulus(1'b1, 8'h15, 1'b1, 1'b0);
        tick();
        checkOutput("t3_no_drop", 32'(drop_cnt), 32'd2);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        for (int k = 1; k < 5; k++) begin
            checkHead($sformatf("t3_drain%0d", k), 8'h11 + 8'(k), tsSeen[k]);
            tick();
        end
        checkEmpty("t3_empty");

        // Saturation of drop_cnt, then clr with and without a same-cycle drop.
        tsSeen[0] = tsModel;
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'b1, 8'(i) + 8'h20, 1'b0, 1'b0);
            tick();
        end
        checkOutput("t5_sat_dropcnt", 32'(drop_cnt), 32'd255);
        checkOutput("t5_sat_overflow", 32'(overflow), 32'd1);
        applyStimulus(1'b1, 8'h4C, 1'b0, 1'b1); tick();
        checkOutput("t5_clrdrop_overflow", 32'(overflow), 32'd1);
        checkOutput("t5_clrdrop_dropcnt",  32'(drop_cnt), 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1); tick();
        checkOutput("t5_clr_overflow", 32'(overflow), 32'd0);
        checkOutput("t5_clr_dropcnt",  32'(drop_cnt), 32'd0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkHead("t5_fifo_kept", 8'h20, tsSeen[0]);

        // Asynchronous reset with a full FIFO and nonzero loss state.
        applyStimulus(1'b1, 8'h4D, 1'b0, 1'b0); tick();
        checkOutput("t4_pre_overflow", 32'(overflow), 32'd1);
        rst = 1'b0;
        #1;
        checkEmpty("t4_async");
        checkOutput("t4_overflow", 32'(overflow), 32'd0);
        checkOutput("t4_dropcnt",  32'(drop_cnt), 32'd0);
        #1;
        rst     = 1'b1;
        tsModel = 8'd0;
        applyStimulus(1'b1, 8'h77, 1'b0, 1'b0); tick();
        checkEmpty("t4_baseline");
        applyStimulus(1'b1, 8'h88, 1'b0, 1'b0); tick();
        checkHead("t4_first_ev", 8'h88, 8'd1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0); tick();
        checkEmpty("t4_drained");

        // Disabled sampling with a changing word, then timestamp wrap.
        for (int guard = 0; guard < 300 && tsModel != 8'd255; guard++) begin
            applyStimulus(1'b0, 8'(guard) ^ 8'hC3, 1'b0, 1'b0);
            tick();
        end
        checkOutput("t6_reached_255", 32'(tsModel), 32'd255);
        checkEmpty("t6_en_low");
        applyStimulus(1'b1, 8'h99, 1'b0, 1'b0); tick();
        applyStimulus(1'b1, 8'h9A, 1'b0, 1'b0); tick();
        checkHead("t6_ts255", 8'h99, 8'hFF);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0); tick();
        checkHead("t6_ts0", 8'h9A, 8'h00);
        tick();
        checkEmpty("t6_empty");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
